// File: rtl/dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_ctrl_pkg
//  Brief    : Shared encodings for the dmem arbiter: access sizes, FSM states,
//             unshifted write masks and the latched request record.
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_ctrl_pkg;

  localparam int XLEN = 32;

  // Access size encodings carried on size0/size1
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Unshifted write masks; dmem applies the byte-lane shift itself
  localparam logic [XLEN-1:0] MASK_NONE = 32'h0000_0000;
  localparam logic [XLEN-1:0] MASK_BYTE = 32'h0000_00FF;
  localparam logic [XLEN-1:0] MASK_HALF = 32'h0000_FFFF;
  localparam logic [XLEN-1:0] MASK_WORD = 32'hFFFF_FFFF;

  // Request fields captured on the grant edge
  typedef struct packed {
    logic            port;
    logic            we;
    logic [1:0]      size;
    logic            uns;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } acc_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_align.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_align
//  Brief    : Combinational access checker: misalign / reserved-size error,
//             unshifted write mask, and load lane shift with sign/zero extend.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]      size_i,
  input  logic [1:0]      addr_lo_i,
  input  logic            uns_i,
  input  logic [XLEN-1:0] rword_i,
  output logic            err_o,
  output logic [XLEN-1:0] wmask_o,
  output logic [XLEN-1:0] ldata_o
);

  logic [XLEN-1:0] w_shifted;
  logic            w_sign;

  // Flag reserved sizes and accesses not aligned to their own size
  always_comb begin
    case (size_i)
      SZ_BYTE: err_o = 1'b0;
      SZ_HALF: err_o = addr_lo_i[0];
      SZ_WORD: err_o = (addr_lo_i != 2'b00);
      default: err_o = 1'b1;
    endcase
  end

  // Write mask depends on size only; reserved size writes nothing
  always_comb begin
    case (size_i)
      SZ_BYTE: wmask_o = MASK_BYTE;
      SZ_HALF: wmask_o = MASK_HALF;
      SZ_WORD: wmask_o = MASK_WORD;
      default: wmask_o = MASK_NONE;
    endcase
  end

  // Move the addressed lane to bit 0, truncate to size, then extend
  always_comb begin
    w_shifted = rword_i >> {addr_lo_i, 3'b000};
    w_sign    = 1'b0;
    ldata_o   = '0;
    if (!err_o) begin
      case (size_i)
        SZ_BYTE: begin
          w_sign  = ~uns_i & w_shifted[7];
          ldata_o = {{(XLEN-8){w_sign}}, w_shifted[7:0]};
        end
        SZ_HALF: begin
          w_sign  = ~uns_i & w_shifted[15];
          ldata_o = {{(XLEN-16){w_sign}}, w_shifted[15:0]};
        end
        SZ_WORD: ldata_o = w_shifted;
        default: ldata_o = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Brief    : Two-port arbiter and IDLE/ACCESS/RESP sequencer in front of the
//             single-port data memory. Port 0 = core LSU, port 1 = debug.
//             Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
//             otherwise port 0 has fixed priority.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      req_i,
  input  logic [1:0]      we_i,
  input  logic [1:0]      size0_i,
  input  logic [1:0]      size1_i,
  input  logic [1:0]      uns_i,
  input  logic [XLEN-1:0] addr0_i,
  input  logic [XLEN-1:0] addr1_i,
  input  logic [XLEN-1:0] wdata0_i,
  input  logic [XLEN-1:0] wdata1_i,
  output logic [1:0]      gnt_o,
  output logic [1:0]      rvalid_o,
  output logic            rerr_o,
  output logic [XLEN-1:0] rdata_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [XLEN-1:0] mem_wmask_o,
  output logic            mem_we_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  state_e          state_q, state_d;
  acc_req_t        req_q, req_d;
  logic            rerr_q, rerr_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            w_arb_ok;
  logic            w_grant;
  logic            w_win;
  acc_req_t        w_sel;
  logic            w_err;
  logic [XLEN-1:0] w_wmask;
  logic [XLEN-1:0] w_ldata;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Port granted most recently; reset value 1 makes port 0 win first
  logic            last_q, last_d;
`endif

  // Pick a winner whenever the sequencer is free to accept (IDLE or RESP)
  always_comb begin
    w_arb_ok = (state_q == ST_IDLE) || (state_q == ST_RESP);
    w_grant  = rst_ni && w_arb_ok && (req_i != 2'b00);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    w_win    = (req_i == 2'b11) ? ~last_q : req_i[1];
`else
    w_win    = ~req_i[0];
`endif
    w_sel       = '0;
    w_sel.port  = w_win;
    w_sel.we    = we_i[w_win];
    w_sel.size  = w_win ? size1_i  : size0_i;
    w_sel.uns   = uns_i[w_win];
    w_sel.addr  = w_win ? addr1_i  : addr0_i;
    w_sel.wdata = w_win ? wdata1_i : wdata0_i;
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Pointer moves only when a grant is actually issued
  always_comb begin
    last_d = w_grant ? w_win : last_q;
  end

  // Round-robin pointer register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Single checker instance works on the latched request only
  dmem_align u_align (
    .size_i    (req_q.size),
    .addr_lo_i (req_q.addr[1:0]),
    .uns_i     (req_q.uns),
    .rword_i   (mem_rdata_i),
    .err_o     (w_err),
    .wmask_o   (w_wmask),
    .ldata_o   (w_ldata)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: ACCESS always lasts one cycle, RESP may re-grant
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_grant) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = w_grant ? ST_ACCESS : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next state: latch on grant, capture response during ACCESS
  always_comb begin
    req_d   = req_q;
    rerr_d  = rerr_q;
    rdata_d = rdata_q;
    if (w_grant) begin
      req_d = w_sel;
    end
    if (state_q == ST_ACCESS) begin
      rerr_d  = w_err;
      rdata_d = req_q.we ? '0 : w_ldata;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_q   <= '0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      req_q   <= req_d;
      rerr_q  <= rerr_d;
      rdata_q <= rdata_d;
    end
  end

  // FSM outputs: memory bus only in ACCESS, response only in RESP
  always_comb begin
    gnt_o       = 2'b00;
    rvalid_o    = 2'b00;
    rerr_o      = 1'b0;
    rdata_o     = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    mem_we_o    = 1'b0;
    if (w_grant) begin
      gnt_o = w_win ? 2'b10 : 2'b01;
    end
    case (state_q)
      ST_ACCESS: begin
        mem_addr_o  = req_q.addr;
        mem_wdata_o = req_q.wdata;
        mem_wmask_o = w_wmask;
        // Reset gates the strobe so a store caught by reset never lands
        mem_we_o    = rst_ni & req_q.we & ~w_err;
      end
      ST_RESP: begin
        rvalid_o = req_q.port ? 2'b10 : 2'b01;
        rerr_o   = rerr_q;
        rdata_o  = rdata_q;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
